// File: rtl/demux_store_pkg.sv
// Shared widths, sel_D encodings and types for the accumulator store path.
package demux_store_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int ADDR_WIDTH = 11;
  localparam int DEPTH      = 2;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_PORT = 2'b10;
  localparam logic [1:0] SEL_BOTH = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } store_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } store_entry_t;

endpackage

// File: rtl/demux_store_fifo.sv
// Ring buffer of pending memory stores; head is read combinationally so the
// drain FSM can present it in the cycle after the push.
module demux_store_fifo
  import demux_store_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  store_entry_t       entry_i,
  input  logic               pop_i,
  output store_entry_t       head_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  store_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push while full is dropped even if the head pops in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/demux_store.sv
// Steers the accumulator to data memory (via a store buffer drained over
// req/ack), to the output port register, or to both.
module demux_store
  import demux_store_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ACC_in,
  input  logic [ADDR_WIDTH-1:0] ADDR_in,
  input  logic                  store_en,
  input  logic [1:0]            sel_D,
  output logic                  stall_out,
  output logic [ADDR_WIDTH-1:0] DM_addr,
  output logic [DATA_WIDTH-1:0] DM_data,
  output logic                  DM_wr_req,
  input  logic                  DM_wr_ack,
  output logic [DATA_WIDTH-1:0] OUT_data,
  output logic                  OUT_strobe
);

  store_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_strobe_q;
  store_entry_t          head;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Stalled stores are dropped as a whole: neither port nor memory is written.
  assign accept    = store_en & ~full & (sel_D != SEL_NONE);
  assign push      = accept & sel_D[0];
  assign pop       = (state_q == REQ) & DM_wr_ack & ~empty;
  assign stall_out = full;

  demux_store_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i ('{addr: ADDR_in, data: ACC_in}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_strobe_q <= accept & sel_D[1];
      if (accept & sel_D[1]) out_data_q <= ACC_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    DM_wr_req = 1'b0;
    DM_addr   = '0;
    DM_data   = '0;
    case (state_q)
      IDLE: begin
        if (push) state_d = REQ;
      end
      REQ: begin
        DM_wr_req = 1'b1;
        DM_addr   = head.addr;
        DM_data   = head.data;
        // Last entry leaving with nothing arriving behind it ends the drain.
        if (pop && (count == CNT_W'(1)) && !push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign OUT_data   = out_data_q;
  assign OUT_strobe = out_strobe_q;

endmodule
